// File: rtl/linear_sensor_seq.sv
// Line-sensor acquisition controller: drives the integration window, waits for
// the sensor start-of-video pulse, captures NUM_CH ADC lanes per pixel and frames each line.
module linear_sensor_seq #(
    parameter int PIX_NUM   = 512,
    parameter int NUM_CH    = 2,
    parameter int ADC_W     = 16,
    parameter int BLANK_CYC = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       sensor_clk_o,
    output logic                       sensor_reset_o,
    input  logic                       ad_sp,
    input  logic [NUM_CH*ADC_W-1:0]    adc_data_in,
    output logic                       pix_valid_o,
    output logic [NUM_CH*ADC_W-1:0]    pix_data_o,
    output logic [$clog2(PIX_NUM)-1:0] pix_idx_o,
    output logic                       pix_sol_o,
    output logic                       pix_eol_o,
    output logic                       done_irq_o,
    input  logic                       wr_in,
    input  logic                       rd_in,
    input  logic [3:0]                 addr_in,
    input  logic [31:0]                data_in,
    output logic [31:0]                rd_data_o,
    output logic                       rd_valid_o
);
    localparam int          IDX_W      = $clog2(PIX_NUM);
    localparam logic [31:0] PIX_LAST   = 32'(PIX_NUM - 1);
    localparam logic [31:0] BLANK_LAST = 32'(BLANK_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INTEG   = 3'd1,
        S_WAIT_SP = 3'd2,
        S_DATA    = 3'd3,
        S_BLANK   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t      state, state_next;
    logic [31:0] cnt;
    logic        cont_reg, cont_lat;
    logic [31:0] integ_reg, lines_reg, sp_timeout_reg;
    logic [31:0] integ_lat, lines_lat, integ_last;
    logic [15:0] line_cnt;
    logic        err, done, busy;
    logic [31:0] rd_mux;
    logic        wr_ctrl, start_req, soft_rst, status_w1c;
    logic        acq_start, sp_timeout_hit, sample, line_last, more_lines;

    assign sensor_clk_o = clk;
    assign wr_ctrl      = wr_in && (addr_in == 4'd0);
    assign start_req    = wr_ctrl && data_in[0];
    assign soft_rst     = wr_ctrl && data_in[2];
    assign status_w1c   = wr_in && (addr_in == 4'd4);
    assign integ_last   = (integ_lat == 32'd0) ? 32'd0 : integ_lat - 32'd1;
    assign more_lines   = cont_lat && ((lines_lat == 32'd0) || ({16'd0, line_cnt} < lines_lat));
    assign acq_start    = (state == S_IDLE) && (state_next == S_INTEG);
    assign sample       = (state == S_DATA) && !soft_rst;
    assign line_last    = sample && (cnt == PIX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next     = state;
        sp_timeout_hit = 1'b0;
        case (state)
            S_IDLE:    if (start_req) state_next = S_INTEG;
            S_INTEG:   if (cnt == integ_last) state_next = S_WAIT_SP;
            S_WAIT_SP: begin
                if (ad_sp) begin
                    state_next = S_DATA;
                end else if ((sp_timeout_reg != 32'd0) && (cnt == sp_timeout_reg - 32'd1)) begin
                    sp_timeout_hit = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            S_DATA:    if (cnt == PIX_LAST) state_next = S_BLANK;
            S_BLANK:   if (cnt == BLANK_LAST) state_next = more_lines ? S_INTEG : S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
        if (soft_rst) begin
            state_next     = S_IDLE;
            sp_timeout_hit = 1'b0;
        end
    end

    always_comb begin
        sensor_reset_o = (state == S_INTEG);
        busy           = (state != S_IDLE);
    end

    // Phase counter restarts on every state change, so each phase counts from zero.
    always_ff @(posedge clk) begin
        if (rst || (state == S_IDLE) || (state_next != state)) cnt <= 32'd0;
        else                                                   cnt <= cnt + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_reg       <= 1'b0;
            integ_reg      <= 32'd0;
            lines_reg      <= 32'd0;
            sp_timeout_reg <= 32'd0;
            cont_lat       <= 1'b0;
            integ_lat      <= 32'd0;
            lines_lat      <= 32'd0;
            line_cnt       <= 16'd0;
            err            <= 1'b0;
            done           <= 1'b0;
        end else begin
            if (wr_in) begin
                case (addr_in)
                    4'd0:    cont_reg       <= data_in[1];
                    4'd1:    integ_reg      <= data_in;
                    4'd2:    lines_reg      <= data_in;
                    4'd3:    sp_timeout_reg <= data_in;
                    default: ;
                endcase
            end
            if (status_w1c && data_in[29]) err  <= 1'b0;
            if (status_w1c && data_in[30]) done <= 1'b0;
            if (acq_start) begin
                cont_lat  <= data_in[1];
                integ_lat <= integ_reg;
                lines_lat <= lines_reg;
                line_cnt  <= 16'd0;
                err       <= 1'b0;
            end
            // Internal sets come last so they win over a same-cycle host clear.
            if (sp_timeout_hit)                 err      <= 1'b1;
            if (line_last)                      line_cnt <= line_cnt + 16'd1;
            if ((state == S_DONE) && !soft_rst) done     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid_o <= 1'b0;
            pix_data_o  <= '0;
            pix_idx_o   <= '0;
            pix_sol_o   <= 1'b0;
            pix_eol_o   <= 1'b0;
            done_irq_o  <= 1'b0;
        end else begin
            pix_valid_o <= sample;
            if (sample) pix_data_o <= adc_data_in;
            pix_idx_o   <= sample ? cnt[IDX_W-1:0] : '0;
            pix_sol_o   <= sample && (cnt == 32'd0);
            pix_eol_o   <= line_last;
            done_irq_o  <= (state == S_DONE) && !soft_rst;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr_in)
            4'd0:    rd_mux = {30'd0, cont_reg, 1'b0};
            4'd1:    rd_mux = integ_reg;
            4'd2:    rd_mux = lines_reg;
            4'd3:    rd_mux = sp_timeout_reg;
            4'd4:    rd_mux = {busy, done, err, 10'd0, state, line_cnt};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_o <= 1'b0;
            rd_data_o  <= 32'd0;
        end else begin
            rd_valid_o <= rd_in;
            rd_data_o  <= rd_in ? rd_mux : 32'd0;
        end
    end
endmodule

// File: tb/tb_linear_sensor_seq.sv
// Directed bench for linear_sensor_seq: single shot, continuous lines, ad_sp
// timeout, soft reset, busy start with mid-line reset, and INTEG=0 with W1C race.
module tb_linear_sensor_seq;
    localparam int PIX = 8;
    localparam int BLK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sensor_clk_o, sensor_reset_o, ad_sp;
    logic [31:0] adc_data_in;
    logic        pix_valid_o;
    logic [31:0] pix_data_o;
    logic [2:0]  pix_idx_o;
    logic        pix_sol_o, pix_eol_o, done_irq_o;
    logic        wr_in, rd_in;
    logic [3:0]  addr_in;
    logic [31:0] data_in, rd_data_o;
    logic        rd_valid_o;

    int n_checks = 0;
    int n_fail   = 0;

    linear_sensor_seq #(.PIX_NUM(PIX), .NUM_CH(2), .ADC_W(16), .BLANK_CYC(BLK)) dut (
        .clk(clk), .rst(rst), .sensor_clk_o(sensor_clk_o), .sensor_reset_o(sensor_reset_o),
        .ad_sp(ad_sp), .adc_data_in(adc_data_in), .pix_valid_o(pix_valid_o),
        .pix_data_o(pix_data_o), .pix_idx_o(pix_idx_o), .pix_sol_o(pix_sol_o),
        .pix_eol_o(pix_eol_o), .done_irq_o(done_irq_o), .wr_in(wr_in), .rd_in(rd_in),
        .addr_in(addr_in), .data_in(data_in), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o)
    );

    always #5 clk = ~clk;

    // Two-lane ramp: lane 0 counts up, lane 1 is its complement.
    function automatic logic [31:0] ramp_word(input logic [31:0] c);
        return {~c[15:0], c[15:0]};
    endfunction

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;
    assign adc_data_in = ramp_word(cyc);

    // Passive monitor: records beats, integration starts and irq pulses at the falling edge.
    logic [2:0]  beat_idx  [256];
    logic        beat_sol  [256];
    logic        beat_eol  [256];
    logic [31:0] beat_data [256];
    logic [31:0] beat_exp  [256];
    int          gap       [64];
    int          beat_n = 0, valid_runs = 0, sr_rises = 0, irq_n = 0;
    logic [31:0] last_valid_cyc = 32'd0;
    logic        prev_valid = 1'b0, prev_sr = 1'b0;

    always @(negedge clk) begin
        if (pix_valid_o) begin
            if (beat_n < 256) begin
                beat_idx[beat_n]  <= pix_idx_o;
                beat_sol[beat_n]  <= pix_sol_o;
                beat_eol[beat_n]  <= pix_eol_o;
                beat_data[beat_n] <= pix_data_o;
                beat_exp[beat_n]  <= ramp_word(cyc - 32'd1);
            end
            beat_n         <= beat_n + 1;
            last_valid_cyc <= cyc;
            if (!prev_valid) valid_runs <= valid_runs + 1;
        end
        if (sensor_reset_o && !prev_sr) begin
            if (sr_rises < 64) gap[sr_rises] <= int'(cyc - last_valid_cyc);
            sr_rises <= sr_rises + 1;
        end
        if (done_irq_o) irq_n <= irq_n + 1;
        prev_valid <= pix_valid_o;
        prev_sr    <= sensor_reset_o;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        wr_in = 1'b1; addr_in = a; data_in = d;
        tick(1);
        wr_in = 1'b0; data_in = 32'd0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d, output logic v);
        rd_in = 1'b1; addr_in = a;
        tick(1);
        rd_in = 1'b0;
        d = rd_data_o;
        v = rd_valid_o;
    endtask

    // Measures the integration window, then raises ad_sp for one cycle after 'delay'
    // WAIT_SP cycles (delay < 0 leaves ad_sp low). Returns in the cycle after the pulse.
    task automatic drive_sp(input int delay, output int integ_len, output bit ok);
        int guard = 0;
        integ_len = 0;
        ok = 1'b0;
        while (!sensor_reset_o && guard < 200) begin tick(1); guard++; end
        while (sensor_reset_o && guard < 200) begin integ_len++; tick(1); guard++; end
        if (guard >= 200) return;
        if (delay >= 0) begin
            tick(delay);
            ad_sp = 1'b1;
            tick(1);
            ad_sp = 1'b0;
        end
        ok = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        logic        v;
        tick(3);
        n_checks++;
        if ({sensor_reset_o, pix_valid_o, pix_sol_o, pix_eol_o, done_irq_o, rd_valid_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: sr/valid/sol/eol/irq/rdv=%b expected 000000",
                     {sensor_reset_o, pix_valid_o, pix_sol_o, pix_eol_o, done_irq_o, rd_valid_o});
        end
        n_checks++;
        if ({pix_data_o, rd_data_o, pix_idx_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_data: pix_data=%h rd_data=%h idx=%0d expected 0", pix_data_o, rd_data_o, pix_idx_o);
        end
        n_checks++;
        if (sensor_clk_o !== clk) begin
            n_fail++;
            $display("FAIL sensor_clk: got %b expected %b", sensor_clk_o, clk);
        end
        rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            reg_read(4'(a), d, v);
            n_checks++;
            if (d !== 32'd0 || v !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_reg%0d: data=%h valid=%b expected 00000000 valid 1", a, d, v);
            end
        end
    endtask

    task automatic test_regs;
        logic [31:0] d;
        logic        v;
        reg_write(4'd2, 32'h1234_5678);
        reg_read(4'd2, d, v);
        n_checks++;
        if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL lines_rw: got %h expected 12345678", d); end
        reg_write(4'd2, 32'd0);
        reg_write(4'd1, 32'd10);
        reg_read(4'd1, d, v);
        n_checks++;
        if (d !== 32'd10) begin n_fail++; $display("FAIL integ_rw: got %h expected 0000000a", d); end
        reg_write(4'd7, 32'hFFFF_FFFF);
        reg_read(4'd7, d, v);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL addr7_read: got %h expected 00000000", d); end
        reg_read(4'd15, d, v);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL addr15_read: got %h expected 00000000", d); end
        reg_write(4'd0, 32'd2);
        reg_read(4'd0, d, v);
        n_checks++;
        if (d !== 32'd2) begin n_fail++; $display("FAIL ctrl_cont_rw: got %h expected 00000002", d); end
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL ctrl_no_start: status %h expected 00000000", d); end
        reg_write(4'd0, 32'd0);
    endtask

    task automatic test_single;
        int b0 = beat_n, vr0 = valid_runs, i0 = irq_n, len;
        bit ok;
        logic [31:0] d;
        logic v;
        reg_write(4'd0, 32'd1);
        n_checks++;
        if (sensor_reset_o !== 1'b1) begin n_fail++; $display("FAIL single_start_latency: sensor_reset_o=%b expected 1", sensor_reset_o); end
        drive_sp(3, len, ok);
        n_checks++;
        if (!ok || len != 10) begin n_fail++; $display("FAIL single_integ_len: got %0d (ok=%0d) expected 10", len, ok); end
        n_checks++;
        if (pix_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_first_beat_early: pix_valid_o=%b expected 0", pix_valid_o); end
        tick(1);
        n_checks++;
        if (pix_valid_o !== 1'b1 || pix_idx_o !== 3'd0) begin
            n_fail++; $display("FAIL single_first_beat: valid=%b idx=%0d expected valid 1 idx 0", pix_valid_o, pix_idx_o);
        end
        tick(20);
        n_checks++;
        if (beat_n - b0 != PIX) begin n_fail++; $display("FAIL single_beats: got %0d expected %0d", beat_n - b0, PIX); end
        for (int k = 0; k < PIX; k++) begin
            n_checks++;
            if (beat_idx[b0+k] !== 3'(k) || beat_sol[b0+k] !== (k == 0) || beat_eol[b0+k] !== (k == PIX - 1)) begin
                n_fail++;
                $display("FAIL single_frame%0d: idx=%0d sol=%b eol=%b expected idx %0d sol %b eol %b",
                         k, beat_idx[b0+k], beat_sol[b0+k], beat_eol[b0+k], k, (k == 0), (k == PIX - 1));
            end
            n_checks++;
            if (beat_data[b0+k] !== beat_exp[b0+k]) begin
                n_fail++; $display("FAIL single_data%0d: got %h expected %h", k, beat_data[b0+k], beat_exp[b0+k]);
            end
        end
        n_checks++;
        if (valid_runs - vr0 != 1) begin n_fail++; $display("FAIL single_contiguous: runs %0d expected 1", valid_runs - vr0); end
        n_checks++;
        if (irq_n - i0 != 1) begin n_fail++; $display("FAIL single_irq: pulses %0d expected 1", irq_n - i0); end
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'h4000_0001) begin n_fail++; $display("FAIL single_status: got %h expected 40000001", d); end
    endtask

    task automatic test_continuous;
        int b0, vr0, r0, i0, len;
        bit ok;
        logic [31:0] d;
        logic v;
        reg_write(4'd4, 32'h4000_0000);
        reg_write(4'd1, 32'd5);
        reg_write(4'd2, 32'd3);
        b0 = beat_n; vr0 = valid_runs; r0 = sr_rises; i0 = irq_n;
        reg_write(4'd0, 32'd3);
        for (int ln = 0; ln < 3; ln++) begin
            drive_sp(1, len, ok);
            n_checks++;
            if (!ok || len != 5) begin n_fail++; $display("FAIL cont_integ_len%0d: got %0d (ok=%0d) expected 5", ln, len, ok); end
        end
        n_checks++;
        if (irq_n - i0 != 0) begin n_fail++; $display("FAIL cont_early_irq: pulses %0d expected 0", irq_n - i0); end
        tick(30);
        n_checks++;
        if (beat_n - b0 != 3 * PIX) begin n_fail++; $display("FAIL cont_beats: got %0d expected %0d", beat_n - b0, 3 * PIX); end
        for (int k = 0; k < 3 * PIX; k++) begin
            n_checks++;
            if (beat_idx[b0+k] !== 3'(k % PIX) || beat_data[b0+k] !== beat_exp[b0+k]) begin
                n_fail++;
                $display("FAIL cont_beat%0d: idx=%0d data=%h expected idx %0d data %h",
                         k, beat_idx[b0+k], beat_data[b0+k], k % PIX, beat_exp[b0+k]);
            end
        end
        n_checks++;
        if (valid_runs - vr0 != 3 || sr_rises - r0 != 3) begin
            n_fail++; $display("FAIL cont_lines: runs %0d integ windows %0d expected 3 and 3", valid_runs - vr0, sr_rises - r0);
        end
        for (int g = 1; g < 3; g++) begin
            n_checks++;
            if (gap[r0+g] != BLK) begin n_fail++; $display("FAIL cont_gap%0d: got %0d cycles expected %0d", g, gap[r0+g], BLK); end
        end
        n_checks++;
        if (irq_n - i0 != 1) begin n_fail++; $display("FAIL cont_irq: pulses %0d expected 1", irq_n - i0); end
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'h4000_0003) begin n_fail++; $display("FAIL cont_status: got %h expected 40000003", d); end
        reg_write(4'd2, 32'd0);
    endtask

    task automatic test_timeout;
        int b0, i0, len;
        bit ok;
        logic [31:0] d;
        logic v;
        reg_write(4'd3, 32'd20);
        reg_write(4'd1, 32'd2);
        b0 = beat_n; i0 = irq_n;
        reg_write(4'd0, 32'd1);
        drive_sp(-1, len, ok);
        n_checks++;
        if (!ok || len != 2) begin n_fail++; $display("FAIL to_integ_len: got %0d (ok=%0d) expected 2", len, ok); end
        tick(19);
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'hC002_0000) begin n_fail++; $display("FAIL to_still_waiting: status %h expected c0020000", d); end
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'h6000_0000) begin n_fail++; $display("FAIL to_err: status %h expected 60000000", d); end
        tick(20);
        n_checks++;
        if (beat_n - b0 != 0 || irq_n - i0 != 0) begin
            n_fail++; $display("FAIL to_quiet: beats %0d irqs %0d expected 0 and 0", beat_n - b0, irq_n - i0);
        end
        reg_write(4'd4, 32'h6000_0000);
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL to_w1c: status %h expected 00000000", d); end
        reg_write(4'd3, 32'd0);
    endtask

    task automatic test_soft_reset;
        int b0, i0, len;
        bit ok;
        logic [31:0] d;
        logic v;
        reg_write(4'd1, 32'd3);
        b0 = beat_n; i0 = irq_n;
        reg_write(4'd0, 32'd1);
        drive_sp(0, len, ok);
        tick(4);
        reg_write(4'd0, 32'd4);
        n_checks++;
        if (pix_valid_o !== 1'b0 || sensor_reset_o !== 1'b0) begin
            n_fail++; $display("FAIL sr_outputs: valid=%b sensor_reset=%b expected 0 0", pix_valid_o, sensor_reset_o);
        end
        tick(20);
        n_checks++;
        if (beat_n - b0 != 4 || irq_n - i0 != 0) begin
            n_fail++; $display("FAIL sr_truncated: beats %0d irqs %0d expected 4 and 0", beat_n - b0, irq_n - i0);
        end
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'd0) begin n_fail++; $display("FAIL sr_status: got %h expected 00000000", d); end
        b0 = beat_n; i0 = irq_n;
        reg_write(4'd0, 32'd1);
        drive_sp(2, len, ok);
        n_checks++;
        if (!ok || len != 3) begin n_fail++; $display("FAIL sr_restart_integ: got %0d (ok=%0d) expected 3", len, ok); end
        tick(20);
        n_checks++;
        if (beat_n - b0 != PIX || irq_n - i0 != 1) begin
            n_fail++; $display("FAIL sr_restart_line: beats %0d irqs %0d expected %0d and 1", beat_n - b0, irq_n - i0, PIX);
        end
        for (int k = 0; k < PIX; k++) begin
            n_checks++;
            if (beat_idx[b0+k] !== 3'(k) || beat_data[b0+k] !== beat_exp[b0+k]) begin
                n_fail++;
                $display("FAIL sr_restart_beat%0d: idx=%0d data=%h expected idx %0d data %h",
                         k, beat_idx[b0+k], beat_data[b0+k], k, beat_exp[b0+k]);
            end
        end
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'h4000_0001) begin n_fail++; $display("FAIL sr_restart_status: got %h expected 40000001", d); end
    endtask

    task automatic test_back_to_back;
        int i0, len;
        bit ok;
        logic [31:0] d;
        logic v;
        reg_write(4'd1, 32'd2);
        i0 = irq_n;
        reg_write(4'd0, 32'd1);
        drive_sp(0, len, ok);
        reg_write(4'd0, 32'd1);
        n_checks++;
        if (sensor_reset_o !== 1'b0 || pix_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL busy_start: sensor_reset=%b valid=%b expected 0 1", sensor_reset_o, pix_valid_o);
        end
        reg_write(4'd1, 32'd7);
        reg_write(4'd2, 32'd9);
        reg_write(4'd3, 32'd5);
        tick(4);
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'hC004_0001) begin n_fail++; $display("FAIL busy_blank_status: got %h expected c0040001", d); end
        rst = 1'b1;
        tick(1);
        n_checks++;
        if ({sensor_reset_o, pix_valid_o, pix_sol_o, pix_eol_o, done_irq_o, rd_valid_o} !== 6'b0 ||
            pix_data_o !== 32'd0 || pix_idx_o !== 3'd0 || rd_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL midblank_rst_outputs: sr/valid/sol/eol/irq/rdv=%b data=%h idx=%0d rd=%h expected all 0",
                     {sensor_reset_o, pix_valid_o, pix_sol_o, pix_eol_o, done_irq_o, rd_valid_o},
                     pix_data_o, pix_idx_o, rd_data_o);
        end
        rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            reg_read(4'(a), d, v);
            n_checks++;
            if (d !== 32'd0) begin n_fail++; $display("FAIL midblank_rst_reg%0d: got %h expected 00000000", a, d); end
        end
        tick(20);
        n_checks++;
        if (irq_n - i0 != 0) begin n_fail++; $display("FAIL midblank_rst_irq: pulses %0d expected 0", irq_n - i0); end
    endtask

    task automatic test_integ0_w1c;
        int i0, len;
        bit ok;
        logic [31:0] d;
        logic v;
        i0 = irq_n;
        reg_write(4'd0, 32'd1);
        drive_sp(0, len, ok);
        n_checks++;
        if (!ok || len != 1) begin n_fail++; $display("FAIL integ0_len: got %0d (ok=%0d) expected 1", len, ok); end
        tick(PIX + BLK);
        n_checks++;
        if (done_irq_o !== 1'b0) begin n_fail++; $display("FAIL integ0_irq_early: done_irq_o=%b expected 0", done_irq_o); end
        reg_write(4'd4, 32'h4000_0000);
        n_checks++;
        if (done_irq_o !== 1'b1) begin n_fail++; $display("FAIL integ0_irq_timing: done_irq_o=%b expected 1", done_irq_o); end
        tick(1);
        n_checks++;
        if (done_irq_o !== 1'b0) begin n_fail++; $display("FAIL integ0_irq_width: done_irq_o=%b expected 0", done_irq_o); end
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'h4000_0001) begin n_fail++; $display("FAIL w1c_race: status %h expected 40000001", d); end
        reg_write(4'd4, 32'h4000_0000);
        reg_read(4'd4, d, v);
        n_checks++;
        if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL w1c_clear: status %h expected 00000001", d); end
        n_checks++;
        if (irq_n - i0 != 1) begin n_fail++; $display("FAIL integ0_irq_count: pulses %0d expected 1", irq_n - i0); end
    endtask

    initial begin
        wr_in = 1'b0; rd_in = 1'b0; ad_sp = 1'b0;
        addr_in = 4'd0; data_in = 32'd0;
        test_reset();
        test_regs();
        test_single();
        test_continuous();
        test_timeout();
        test_soft_reset();
        test_back_to_back();
        test_integ0_w1c();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/linear_sensor_seq.md
# linear_sensor_seq

Parametrised successor to the single-channel G11620 line-sensor controller. It drives the sensor reset/integration window and captures NUM_CH parallel ADC lanes per pixel. It streams each line with pixel index and framing flags, and supports single-shot or continuous multi-line acquisition with an ad_sp timeout. It sits between the host register bus and the downstream pixel buffer, replacing per-sensor hand-built control.

## Interface
- PIX_NUM, 512: pixels per line (≥2).
- NUM_CH, 2: parallel ADC lanes sampled per pixel clock.
- ADC_W, 16: bits per lane.
- BLANK_CYC, 24: blanking cycles after each line (≥1).
- clk  in  1  system clock; also forwarded to sensor.
- rst  in  1  synchronous, active-high reset.
- sensor_clk_o  out  1  = clk (combinational forward).
- sensor_reset_o  out  1  integration window (high = integrate).
- ad_sp  in  1  sensor start-of-video pulse.
- adc_data_in  in  NUM_CH*ADC_W  lane n at [n*ADC_W +: ADC_W].
- pix_valid_o  out  1  pixel beat valid.
- pix_data_o  out  NUM_CH*ADC_W  registered copy of adc_data_in.
- pix_idx_o  out  clog2(PIX_NUM)  pixel index.
- pix_sol_o / pix_eol_o  out  1  first / last pixel of line.
- done_irq_o  out  1  one-cycle pulse at acquisition end.
- wr_in, rd_in  in  1  register write / read strobes.
- addr_in  in  4  register address.
- data_in  in  32  write data.
- rd_data_o  out  32  read data.
- rd_valid_o  out  1  read data valid.

## Operation
- Registers (reset value 0):
  - 0 CTRL: bit0 start (self-clearing), bit1 continuous, bit2 soft_reset (self-clearing).
  - 1 INTEG: integration cycles; 0 is treated as 1.
  - 2 LINES: line count in continuous mode; 0 = unlimited.
  - 3 SP_TIMEOUT: cycles to wait for ad_sp; 0 = disabled.
  - 4 STATUS: [15:0] line_cnt, [18:16] state, 29 err, 30 done, 31 busy. Read-only except W1C on bits 29/30.
  - Addresses 5–15 read 0; writes to them are ignored.
- States: IDLE, INTEG, WAIT_SP, DATA, BLANK, DONE.
  - IDLE: a start write latches INTEG, LINES and mode, clears line_cnt and err, then goes to INTEG. Start in any other state is ignored.
  - INTEG: sensor_reset_o=1 for max(INTEG,1) cycles, then WAIT_SP.
  - WAIT_SP: ad_sp=1 → DATA. If SP_TIMEOUT≠0 and the wait counter reaches SP_TIMEOUT → set err, go to IDLE; no done.
  - DATA: exactly PIX_NUM cycles. Each cycle samples adc_data_in; line_cnt increments on the last cycle (16-bit, wraps).
  - BLANK: BLANK_CYC cycles. Then, if continuous and (LINES=0 or line_cnt<LINES) → INTEG; otherwise → DONE.
  - DONE: one cycle. Sets done, pulses done_irq_o, then IDLE.
- busy = (state≠IDLE).
- Soft reset: a soft_reset write in any state forces IDLE on the next edge. sensor_reset_o and pix_valid_o drop; done and done_irq_o are not asserted; err is unchanged.
- A host W1C on STATUS in the same cycle as an internal set of the same bit: the set wins.
- Register writes to INTEG/LINES/mode during an acquisition take effect only at the next start.

## Timing
- Reset (rst=1): state IDLE. All outputs 0 except sensor_clk_o. All registers 0.
- Start write at edge N → state INTEG at N+1; sensor_reset_o=1 from N+1 through N+INTEG (INTEG≥1).
- ad_sp high in a WAIT_SP cycle → DATA on the next cycle.
- Pixel output: the ADC sample taken in DATA cycle k appears on pix_*_o at cycle k+1.
  - pix_valid_o is high for exactly PIX_NUM consecutive cycles.
  - pix_idx_o runs 0..PIX_NUM-1.
  - pix_sol_o is high with idx 0; pix_eol_o is high with idx PIX_NUM-1.
  - No back-pressure.
- done_irq_o is high in the cycle after DONE.
- Reads: rd_data_o/rd_valid_o are registered, with data returned one cycle after rd_in. rd_valid_o=rd_in delayed by one cycle. Read-during-write returns the old value.

## Test plan
- Single shot, INTEG=10, PIX_NUM=8, NUM_CH=2, ad_sp 3 cycles after integration ends, adc_data_in ramping from 0 → sensor_reset_o high for 10 cycles; 8 beats with idx 0..7, sol on beat 0, eol on beat 7, data equals the ramp; done_irq_o one pulse; STATUS reads busy=0, done=1, line_cnt=1.
- Continuous, LINES=3 → 3 INTEG/DATA/BLANK cycles back-to-back with no IDLE between lines; one done_irq_o after line 3; line_cnt=3.
- SP_TIMEOUT=20, ad_sp held low → err=1 after 20 WAIT_SP cycles; IDLE; no pixel beats; no done_irq_o.
- Soft reset at DATA beat 4 → pix_valid_o low from the next cycle; IDLE; done=0; a following start produces a clean full line.
- Start written while busy, plus rst asserted mid-BLANK → the start is ignored; reset forces all outputs and registers to 0.
- INTEG=0; and W1C of done in the same cycle as DONE → integration lasts 1 cycle; done reads 1.
